// File: rtl/io_scan_controller.sv
`default_nettype none
// ============================================================================
// Module   : io_scan_controller
// Function : Backplane I/O scanner; writes one byte to and debounces one byte
//            from each installed board per scan.
// Revision : 1.0 - initial release
// ============================================================================
module io_scan_controller #(
    parameter int BOARDS           = 16,
    parameter int INSTALLED_BOARDS = 2,
    parameter int ADDR_WIDTH       = 4,
    parameter int SETUP_CYCLES     = 2,
    parameter int STROBE_CYCLES    = 4,
    parameter int DEBOUNCE         = 3
) (
    input  logic                  Clk,
    input  logic                  Rst_n,
    input  logic                  Scan_en,
    input  logic                  Scan_req,
    output logic [ADDR_WIDTH-1:0] io_address,
    output logic [1:0]            io_enable_n,
    output logic [7:0]            io_data_out,
    output logic                  io_data_oe,
    input  logic [7:0]            io_data_in,
    input  logic [BOARDS*8-1:0]   outputs,
    output logic [BOARDS*8-1:0]   inputs,
    output logic [BOARDS-1:0]     changed_mask,
    output logic                  scan_done
);

    localparam int c_max_phase = (SETUP_CYCLES > STROBE_CYCLES) ? SETUP_CYCLES : STROBE_CYCLES;
    localparam int c_cnt_w     = (c_max_phase > 1) ? $clog2(c_max_phase) : 1;
    localparam int c_db_w      = $clog2(DEBOUNCE + 1);

    localparam logic [c_cnt_w-1:0]    c_setup_last  = c_cnt_w'(SETUP_CYCLES - 1);
    localparam logic [c_cnt_w-1:0]    c_strobe_last = c_cnt_w'(STROBE_CYCLES - 1);
    localparam logic [ADDR_WIDTH-1:0] c_last_board  = ADDR_WIDTH'(INSTALLED_BOARDS - 1);
    localparam logic [c_db_w-1:0]     c_db_max      = c_db_w'(DEBOUNCE);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_W_SETUP  = 3'd1,
        S_W_STROBE = 3'd2,
        S_W_HOLD   = 3'd3,
        S_R_SETUP  = 3'd4,
        S_R_STROBE = 3'd5,
        S_NEXT     = 3'd6
    } state_t;

    state_t                state_q, state_d;
    logic [c_cnt_w-1:0]    cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] board_q, board_d;
    logic [7:0]            dout_q, dout_d;
    logic [7:0]            w_snap;
    logic                  w_load;
    logic                  w_clr_chg;
    logic                  w_sample;

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            board_q <= '0;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            board_q <= board_d;
            dout_q  <= dout_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + 1'b1;
        board_d   = board_q;
        w_load    = 1'b0;
        w_clr_chg = 1'b0;
        w_sample  = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (Scan_en || Scan_req) begin
                    state_d   = S_W_SETUP;
                    board_d   = '0;
                    w_load    = 1'b1;
                    w_clr_chg = 1'b1;
                end
            end
            S_W_SETUP: begin
                if (cnt_q == c_setup_last) begin
                    state_d = S_W_STROBE;
                    cnt_d   = '0;
                end
            end
            S_W_STROBE: begin
                if (cnt_q == c_strobe_last) begin
                    state_d = S_W_HOLD;
                    cnt_d   = '0;
                end
            end
            S_W_HOLD: begin
                state_d = S_R_SETUP;
                cnt_d   = '0;
            end
            S_R_SETUP: begin
                if (cnt_q == c_setup_last) begin
                    state_d = S_R_STROBE;
                    cnt_d   = '0;
                end
            end
            S_R_STROBE: begin
                if (cnt_q == c_strobe_last) begin
                    state_d  = S_NEXT;
                    cnt_d    = '0;
                    w_sample = 1'b1;
                end
            end
            S_NEXT: begin
                cnt_d = '0;
                if (board_q != c_last_board) begin
                    state_d = S_W_SETUP;
                    board_d = board_q + 1'b1;
                    w_load  = 1'b1;
                end else if (Scan_en) begin
                    state_d   = S_W_SETUP;
                    board_d   = '0;
                    w_load    = 1'b1;
                    w_clr_chg = 1'b1;
                end else begin
                    state_d = S_IDLE;
                    board_d = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                board_d = '0;
            end
        endcase
    end

    // Snapshot of the board about to be written, so the bus byte cannot move mid-write.
    always_comb begin
        w_snap = '0;
        for (int b = 0; b < INSTALLED_BOARDS; b++) begin
            if (board_d == ADDR_WIDTH'(b)) begin
                w_snap = outputs[b*8 +: 8];
            end
        end
    end

    always_comb begin
        dout_d = dout_q;
        if (w_load) begin
            dout_d = w_snap;
        end else if (state_d == S_IDLE) begin
            dout_d = '0;
        end
    end

    always_comb begin
        io_address  = board_q;
        io_enable_n = 2'b11;
        io_data_oe  = 1'b0;
        scan_done   = 1'b0;
        case (state_q)
            S_IDLE:     io_address = '0;
            S_W_SETUP:  io_data_oe = 1'b1;
            S_W_STROBE: begin
                io_data_oe     = 1'b1;
                io_enable_n[0] = 1'b0;
            end
            S_W_HOLD:   io_data_oe = 1'b1;
            S_R_SETUP:  io_data_oe = 1'b0;
            S_R_STROBE: io_enable_n[1] = 1'b0;
            S_NEXT:     scan_done = (board_q == c_last_board);
            default:    io_address = '0;
        endcase
    end

    assign io_data_out = dout_q;

    for (genvar b = 0; b < BOARDS; b++) begin : g_board
        if (b < INSTALLED_BOARDS) begin : g_inst
            localparam logic [ADDR_WIDTH-1:0] c_idx = ADDR_WIDTH'(b);

            logic [7:0]        cand_q, cand_d;
            logic [7:0]        byte_q;
            logic [c_db_w-1:0] dbc_q, dbc_d;
            logic              chg_q;
            logic              w_hit;
            logic              w_accept;

            always_comb begin
                cand_d = cand_q;
                dbc_d  = dbc_q;
                w_hit  = w_sample && (board_q == c_idx);
                if (w_hit) begin
                    if (io_data_in == cand_q) begin
                        dbc_d = (dbc_q == c_db_max) ? c_db_max : dbc_q + 1'b1;
                    end else begin
                        cand_d = io_data_in;
                        dbc_d  = c_db_w'(1);
                    end
                end
                w_accept = w_hit && (dbc_d == c_db_max) && (cand_d != byte_q);
            end

            always_ff @(posedge Clk) begin
                if (!Rst_n) begin
                    cand_q <= '0;
                    dbc_q  <= '0;
                    byte_q <= '0;
                    chg_q  <= 1'b0;
                end else begin
                    cand_q <= cand_d;
                    dbc_q  <= dbc_d;
                    if (w_accept) begin
                        byte_q <= cand_d;
                    end
                    if (w_clr_chg) begin
                        chg_q <= 1'b0;
                    end else if (w_accept) begin
                        chg_q <= 1'b1;
                    end
                end
            end

            assign inputs[b*8 +: 8] = byte_q;
            assign changed_mask[b]  = chg_q;
        end else begin : g_empty
            assign inputs[b*8 +: 8] = 8'h00;
            assign changed_mask[b]  = 1'b0;
        end
    end

    if (INSTALLED_BOARDS < BOARDS) begin : g_unused
        logic w_unused_outputs;
        assign w_unused_outputs = ^outputs[BOARDS*8-1:INSTALLED_BOARDS*8];
    end

endmodule
`default_nettype wire

// File: tb/tb_io_scan_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_io_scan_controller
// Function : Self-checking bench for io_scan_controller with write/scan
//            scoreboards and a per-scan vector table.
// Revision : 1.0 - initial release
// ============================================================================
module tb_io_scan_controller;

    logic         Clk = 1'b0;
    logic         Rst_n;
    logic         Scan_en;
    logic         Scan_req;
    logic [3:0]   io_address;
    logic [1:0]   io_enable_n;
    logic [7:0]   io_data_out;
    logic         io_data_oe;
    logic [7:0]   io_data_in;
    logic [127:0] outputs_v;
    logic [127:0] inputs;
    logic [15:0]  changed_mask;
    logic         scan_done;
    logic [7:0]   pad0, pad1;

    always #5 Clk = ~Clk;

    io_scan_controller #(
        .BOARDS(16), .INSTALLED_BOARDS(2), .ADDR_WIDTH(4),
        .SETUP_CYCLES(2), .STROBE_CYCLES(4), .DEBOUNCE(3)
    ) dut (
        .Clk(Clk), .Rst_n(Rst_n), .Scan_en(Scan_en), .Scan_req(Scan_req),
        .io_address(io_address), .io_enable_n(io_enable_n),
        .io_data_out(io_data_out), .io_data_oe(io_data_oe),
        .io_data_in(io_data_in), .outputs(outputs_v), .inputs(inputs),
        .changed_mask(changed_mask), .scan_done(scan_done)
    );

    // Pad model: each board answers with its own byte when addressed.
    assign io_data_in = (io_address == 4'd0) ? pad0 :
                        (io_address == 4'd1) ? pad1 : 8'hEE;

    typedef struct { logic [3:0] addr; logic [7:0] data; } wr_t;
    typedef struct { logic [15:0] inp; logic [1:0] chg; } scan_t;
    typedef struct {
        logic [7:0]  out0, out1, pad0, pad1;
        logic [15:0] exp_in;
        logic [1:0]  exp_chg;
    } vec_t;

    wr_t   exp_wr[$];
    scan_t exp_scan[$];
    vec_t  tbl[15];

    int   n_cmp  = 0;
    int   n_fail = 0;
    int   viol   = 0;
    logic wr_chk = 1'b1;
    logic scan_chk = 1'b1;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Write scoreboard: every strobe pops one expected {addr,data}.
    logic       prev_en0 = 1'b1;
    int         strb_len = 0;
    logic [7:0] cur_dat  = 8'h00;
    logic       dat_bad  = 1'b0;
    always @(negedge Clk) begin
        wr_t w;
        #1;
        if (!io_enable_n[0]) begin
            if (prev_en0) begin
                strb_len = 1;
                dat_bad  = 1'b0;
                cur_dat  = io_data_out;
                if (wr_chk) begin
                    if (exp_wr.size() == 0) begin
                        n_cmp++; n_fail++;
                        $display("FAIL wr_unexpected: addr=%0h data=%0h expected no write", io_address, io_data_out);
                    end else begin
                        w = exp_wr.pop_front();
                        cur_dat = w.data;
                        chk("wr_addr", io_address, w.addr);
                        chk("wr_data", io_data_out, w.data);
                        chk("wr_oe", io_data_oe, 1'b1);
                    end
                end
            end else begin
                strb_len++;
            end
            if (io_data_out !== cur_dat) dat_bad = 1'b1;
        end else if (!prev_en0 && wr_chk) begin
            chk("wr_strobe_len", strb_len, 4);
            chk("wr_data_stable", dat_bad, 1'b0);
        end
        prev_en0 = io_enable_n[0];
    end

    // Scan scoreboard: each scan_done pops expected inputs/changed_mask.
    always @(negedge Clk) begin
        scan_t s;
        #1;
        if (scan_chk && scan_done) begin
            if (exp_scan.size() == 0) begin
                n_cmp++; n_fail++;
                $display("FAIL scan_unexpected: scan_done with inputs=%0h expected none", inputs[15:0]);
            end else begin
                s = exp_scan.pop_front();
                chk("scan_inputs", inputs[15:0], s.inp);
                chk("scan_changed", changed_mask, {14'b0, s.chg});
            end
        end
    end

    // Bus-safety monitor, summarised as one comparison at the end.
    logic prev_oe = 1'b0;
    always @(negedge Clk) begin
        #1;
        if (io_data_oe && !io_enable_n[1]) viol++;
        if (!io_enable_n[1] && prev_oe) viol++;
        if (io_address > 4'd1) viol++;
        if (inputs[127:16] != '0) viol++;
        prev_oe = io_data_oe;
    end

    task automatic wait_done(input string nm);
        int k = 0;
        do begin
            @(negedge Clk);
            k++;
        end while (!scan_done && k < 200);
        if (!scan_done) begin
            n_cmp++; n_fail++;
            $display("FAIL %s: scan_done not seen within 200 cycles", nm);
        end
    endtask

    task automatic wait_strobe(input logic [3:0] a);
        int k = 0;
        do begin
            @(negedge Clk);
            k++;
        end while (!(io_enable_n[0] == 1'b0 && io_address == a) && k < 100);
        if (io_enable_n[0] != 1'b0) begin
            n_cmp++; n_fail++;
            $display("FAIL wait_strobe: write strobe for board %0d not seen within 100 cycles", a);
        end
    endtask

    task automatic push_writes(input logic [7:0] d0, input logic [7:0] d1);
        exp_wr.push_back('{addr: 4'd0, data: d0});
        exp_wr.push_back('{addr: 4'd1, data: d1});
    endtask

    task automatic apply_row(input int r);
        outputs_v[7:0]  = tbl[r].out0;
        outputs_v[15:8] = tbl[r].out1;
        pad0 = tbl[r].pad0;
        pad1 = tbl[r].pad1;
        push_writes(tbl[r].out0, tbl[r].out1);
        exp_scan.push_back('{inp: tbl[r].exp_in, chg: tbl[r].exp_chg});
    endtask

    task automatic pulse_req();
        Scan_req = 1'b1;
        @(negedge Clk);
        Scan_req = 1'b0;
    endtask

    task automatic check_idle(input string nm, input int cycles);
        logic bad = 1'b0;
        repeat (cycles) begin
            @(negedge Clk);
            if (io_enable_n != 2'b11 || io_data_oe || io_address != 4'd0 || scan_done) bad = 1'b1;
        end
        chk(nm, bad, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        n_fail++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        logic early;
        tbl[0]  = '{8'h01, 8'h80, 8'h00, 8'h3C, 16'h0000, 2'b00};
        tbl[1]  = '{8'h02, 8'h40, 8'h00, 8'h3C, 16'h0000, 2'b00};
        tbl[2]  = '{8'h04, 8'h20, 8'h00, 8'h3C, 16'h3C00, 2'b10};
        tbl[3]  = '{8'h08, 8'h10, 8'h00, 8'h3C, 16'h3C00, 2'b00};
        tbl[4]  = '{8'h10, 8'h08, 8'h11, 8'h3C, 16'h3C00, 2'b00};
        tbl[5]  = '{8'h20, 8'h04, 8'h22, 8'h3C, 16'h3C00, 2'b00};
        tbl[6]  = '{8'h40, 8'h02, 8'h11, 8'h3C, 16'h3C00, 2'b00};
        tbl[7]  = '{8'h80, 8'h01, 8'h22, 8'h3C, 16'h3C00, 2'b00};
        tbl[8]  = '{8'hFF, 8'h00, 8'h22, 8'h3C, 16'h3C00, 2'b00};
        tbl[9]  = '{8'h00, 8'hFF, 8'h22, 8'hC3, 16'h3C22, 2'b01};
        tbl[10] = '{8'h5A, 8'hA5, 8'h22, 8'hC3, 16'h3C22, 2'b00};
        tbl[11] = '{8'hA5, 8'h5A, 8'h22, 8'hC3, 16'hC322, 2'b10};
        tbl[12] = '{8'h33, 8'hCC, 8'h00, 8'hC3, 16'hC322, 2'b00};
        tbl[13] = '{8'hCC, 8'h33, 8'h00, 8'hC3, 16'hC322, 2'b00};
        tbl[14] = '{8'h96, 8'h69, 8'h00, 8'hC3, 16'hC300, 2'b01};

        Rst_n = 1'b0; Scan_en = 1'b0; Scan_req = 1'b0;
        outputs_v = '0; pad0 = 8'h00; pad1 = 8'h00;
        repeat (3) @(negedge Clk);
        chk("reset_enable_n", io_enable_n, 2'b11);
        chk("reset_oe", io_data_oe, 1'b0);
        chk("reset_addr_data", {io_address, io_data_out}, 12'h000);
        chk("reset_inputs_mask_done", {inputs, changed_mask, scan_done}, '0);
        Rst_n = 1'b1;
        @(negedge Clk);

        // Single scan via Scan_req; a second request mid-scan must be ignored.
        outputs_v[15:0] = 16'hA55A;
        push_writes(8'h5A, 8'hA5);
        exp_scan.push_back('{inp: 16'h0000, chg: 2'b00});
        pulse_req();
        chk("first_drive", {io_address, io_data_oe}, {4'd0, 1'b1});
        early = 1'b0;
        for (int k = 2; k <= 27; k++) begin
            Scan_req = (k == 10);
            @(negedge Clk);
            if (scan_done) early = 1'b1;
        end
        Scan_req = 1'b0;
        @(negedge Clk);
        chk("done_cycle_28", scan_done, 1'b1);
        chk("done_not_early", early, 1'b0);
        check_idle("idle_after_single", 10);

        Rst_n = 1'b0;
        repeat (2) @(negedge Clk);
        Rst_n = 1'b1;
        @(negedge Clk);

        // Continuous scanning driven from the vector table.
        apply_row(0);
        Scan_en = 1'b1;
        for (int r = 0; r < 15; r++) begin
            wait_done("table_scan");
            if (r < 14) apply_row(r + 1);
            if (r == 13) begin
                repeat (5) @(negedge Clk);
                Scan_en = 1'b0;
            end
        end
        check_idle("idle_after_scan_en_drop", 20);

        // Reset in the middle of a write strobe.
        outputs_v[15:0] = 16'h1234;
        push_writes(8'h34, 8'h12);
        pulse_req();
        wait_strobe(4'd0);
        @(negedge Clk);
        wr_chk = 1'b0;
        Rst_n  = 1'b0;
        @(negedge Clk);
        chk("midrst_enable_n", io_enable_n, 2'b11);
        chk("midrst_oe", io_data_oe, 1'b0);
        chk("midrst_inputs", inputs, '0);
        chk("midrst_addr", io_address, 4'd0);
        Rst_n = 1'b1;
        exp_wr.delete();
        check_idle("idle_after_midrst", 30);
        wr_chk = 1'b1;

        // Outputs change during board 0's strobe: old byte now, new byte next scan.
        pad0 = 8'h00; pad1 = 8'h00;
        outputs_v[15:0] = 16'h7701;
        push_writes(8'h01, 8'h77);
        exp_scan.push_back('{inp: 16'h0000, chg: 2'b00});
        pulse_req();
        wait_strobe(4'd0);
        outputs_v[7:0] = 8'h02;
        wait_done("snap_scan1");
        push_writes(8'h02, 8'h77);
        exp_scan.push_back('{inp: 16'h0000, chg: 2'b00});
        @(negedge Clk);
        pulse_req();
        wait_done("snap_scan2");
        @(negedge Clk);

        // 100 continuous scans with random traffic.
        scan_chk = 1'b0;
        outputs_v[15:0] = 16'($urandom);
        pad0 = 8'($urandom_range(255));
        pad1 = 8'($urandom_range(255));
        push_writes(outputs_v[7:0], outputs_v[15:8]);
        Scan_en = 1'b1;
        for (int s = 0; s < 100; s++) begin
            wait_done("long_run");
            if (s < 99) begin
                outputs_v[15:0] = 16'($urandom);
                pad0 = 8'($urandom_range(255));
                pad1 = 8'($urandom_range(255));
                push_writes(outputs_v[7:0], outputs_v[15:8]);
            end
            if (s == 98) begin
                repeat (3) @(negedge Clk);
                Scan_en = 1'b0;
            end
        end
        repeat (20) @(negedge Clk);

        chk("bus_safety_violations", viol, 0);
        chk("writes_left", exp_wr.size(), 0);
        chk("scans_left", exp_scan.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/io_scan_controller.md
# io_scan_controller

Parametrised scanner for the emulator's backplane I/O bus, sitting between the board connectors and the console and register logic. Each scan visits every installed board in turn. For each board it writes one output byte, then reads back and debounces one input byte. It exposes flat input/output register vectors, a per-scan changed-board mask, and a scan-done pulse, and supports continuous or one-shot scanning. The tri-state data bus is split into in/out/oe so the top level owns the pad.

## Interface
- BOARDS, 16, number of board slots; register vectors are BOARDS*8 bits.
- INSTALLED_BOARDS, 2, boards actually scanned (slots 0..INSTALLED_BOARDS-1); 1 ≤ INSTALLED_BOARDS ≤ BOARDS.
- ADDR_WIDTH, 4, board address width; 2^ADDR_WIDTH ≥ BOARDS.
- SETUP_CYCLES, 2, address/data setup before a strobe; ≥ 1.
- STROBE_CYCLES, 4, strobe low time; ≥ 1.
- DEBOUNCE, 3, consecutive equal samples required before an input byte is accepted; ≥ 1.

Ports:
- Clk  in  1  single clock; all logic on rising edge.
- Rst_n  in  1  synchronous, active-low reset.
- Scan_en  in  1  1 = continuous scanning; 0 = finish the current scan, then idle.
- Scan_req  in  1  one-cycle pulse; starts a single scan when idle.
- io_address  out  ADDR_WIDTH  board select.
- io_enable_n  out  2  bit0 = output latch strobe, bit1 = input buffer enable; both active-low.
- io_data_out  out  8  byte driven during write.
- io_data_oe  out  1  1 = top level drives io_data_out onto the pad.
- io_data_in  in  8  pad readback.
- outputs  in  BOARDS*8  byte b = outputs[8b+7:8b].
- inputs  out  BOARDS*8  debounced input bytes; uninstalled slots are constant 0.
- changed_mask  out  BOARDS  boards whose input byte changed during the last scan; valid while scan_done = 1.
- scan_done  out  1  one-cycle pulse at the end of each scan.

## Operation
- Reset values: io_address = 0, io_enable_n = 2'b11, io_data_out = 0, io_data_oe = 0, inputs = 0, changed_mask = 0, scan_done = 0, FSM in IDLE, all debounce candidates and counters at 0.
- FSM states: IDLE → W_SETUP → W_STROBE → W_HOLD → R_SETUP → R_STROBE → NEXT.
- IDLE: outputs inactive (same values as reset). The FSM leaves IDLE when Scan_en = 1 or Scan_req = 1, setting board = 0 and clearing changed_mask.
- W_SETUP: lasts SETUP_CYCLES.
  - Snapshot the outputs byte of the current board into io_data_out on entry.
  - io_address = board, io_data_oe = 1.
- W_STROBE: lasts STROBE_CYCLES; io_enable_n[0] = 0.
- W_HOLD: lasts 1 cycle; io_enable_n[0] = 1, io_data_oe remains 1.
- R_SETUP: lasts SETUP_CYCLES; io_data_oe = 0, io_enable_n[1] = 1.
- R_STROBE: lasts STROBE_CYCLES; io_enable_n[1] = 0. io_data_in is sampled on the last cycle of the strobe.
- NEXT: lasts 1 cycle, enables high.
  - If board < INSTALLED_BOARDS-1: board++, go to W_SETUP.
  - Otherwise: pulse scan_done. If Scan_en = 1, go to W_SETUP with board = 0 and clear changed_mask on that transition. Otherwise go to IDLE; changed_mask holds.
- Debounce, per board, applied at each sample:
  - If sample == candidate: count = min(count+1, DEBOUNCE).
  - Otherwise: candidate = sample, count = 1.
  - If the new count == DEBOUNCE and candidate ≠ the inputs byte: inputs byte = candidate and changed_mask[b] = 1.
  - DEBOUNCE = 1 accepts every new sample immediately.
- The outputs snapshot prevents a mid-write change on the outputs port from reaching the bus. A change takes effect on the next visit to that board.
- Scan_req while busy is ignored. Scan_en falling mid-scan completes the scan.
- Rst_n low in any state forces the reset values on the next edge, with no completion of the current board.
- io_data_oe and io_enable_n[1] are never both active. At least one full cycle separates the oe-off edge from the read-enable-on edge.

## Timing
- Per board: 2*(SETUP_CYCLES+STROBE_CYCLES)+2 cycles; 14 with defaults.
- Per scan: INSTALLED_BOARDS times the per-board figure; 28 with defaults. Continuous scans run back-to-back with no gap.
- From IDLE, io_address and io_data_oe become valid 1 cycle after Scan_req or Scan_en.
- An inputs byte updates on the edge after its accepting sample.
- scan_done rises one cycle after the last board's R_STROBE.
- Minimum input latency is DEBOUNCE scans.

## Test plan
- Reset mid-W_STROBE (Rst_n low 1 cycle) → next edge: io_enable_n = 11, io_data_oe = 0, inputs = 0, FSM idle.
- Scan_req pulse, outputs[15:0] = 16'hA55A, defaults:
  - Board 0 writes 5A with io_enable_n[0] low for 4 cycles.
  - Board 1 writes A5.
  - scan_done pulses exactly 28 cycles after the first io_address drive.
  - FSM then returns to idle.
- Scan_en = 1, board 1 pad reads 3C constantly → inputs[15:8] = 3C after the 3rd scan, changed_mask = 2'b10 on that scan_done, 0 on the 4th.
- Board 0 input alternates 11/22 every scan with DEBOUNCE = 3 → inputs[7:0] stays 00 and changed_mask[0] never sets.
- Change outputs[7:0] from 01 to 02 during board 0 W_STROBE → bus still carries 01 this scan, 02 next scan.
- INSTALLED_BOARDS = 2, BOARDS = 16: io_address never exceeds 1; inputs[127:16] = 0; oe and read-enable never overlap (assertion across 100 scans).
